// File: rtl/pzcorebus_request_scheduler_if.sv
// Bus bundle between the requesters, the scheduler and the shared corebus request path.
// The slave modport is the scheduler's view and the master modport is the surroundings' view.
interface pzcorebus_request_scheduler_if #(
    parameter int REQUESTERS = 2
);
    localparam int SEL_WIDTH = $clog2(REQUESTERS);

    logic [REQUESTERS-1:0] i_mcmd_valid;
    logic [REQUESTERS-1:0] i_mcmd_with_data;
    logic [REQUESTERS-1:0] o_scmd_accept;
    logic [REQUESTERS-1:0] i_mdata_valid;
    logic [REQUESTERS-1:0] i_mdata_last;
    logic [REQUESTERS-1:0] o_sdata_accept;
    logic                  o_mcmd_valid;
    logic                  i_scmd_accept;
    logic [SEL_WIDTH-1:0]  o_command_select;
    logic                  o_mdata_valid;
    logic                  o_mdata_last;
    logic                  i_sdata_accept;
    logic [SEL_WIDTH-1:0]  o_data_select;

    modport slave (
        input  i_mcmd_valid, i_mcmd_with_data, i_mdata_valid, i_mdata_last,
        input  i_scmd_accept, i_sdata_accept,
        output o_scmd_accept, o_sdata_accept, o_mcmd_valid, o_command_select,
        output o_mdata_valid, o_mdata_last, o_data_select
    );

    modport master (
        output i_mcmd_valid, i_mcmd_with_data, i_mdata_valid, i_mdata_last,
        output i_scmd_accept, i_sdata_accept,
        input  o_scmd_accept, o_sdata_accept, o_mcmd_valid, o_command_select,
        input  o_mdata_valid, o_mdata_last, o_data_select
    );
endinterface

// File: rtl/pzcorebus_request_scheduler.sv
// Round-robin command arbiter for a shared corebus request path; write data bursts
// follow the command grant order through a small FIFO of requester indices.
module pzcorebus_request_scheduler #(
    parameter int  REQUESTERS      = 2,
    parameter int  DATA_FIFO_DEPTH = 4,
    localparam int SEL_WIDTH       = $clog2(REQUESTERS)
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    pzcorebus_request_scheduler_if.slave   bus
);
    localparam int                   PTR_W   = $clog2(DATA_FIFO_DEPTH);
    localparam int                   CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0]     DEPTH_C = CNT_W'(DATA_FIFO_DEPTH);
    localparam logic [SEL_WIDTH:0]   REQ_C   = (SEL_WIDTH + 1)'(REQUESTERS);
    localparam logic [SEL_WIDTH-1:0] LAST_C  = SEL_WIDTH'(REQUESTERS - 1);

    logic [SEL_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  lock_q, lock_d;
    logic [SEL_WIDTH-1:0]  cmd_sel_q, cmd_sel_d;
    logic [SEL_WIDTH-1:0]  fifo_q [DATA_FIFO_DEPTH];
    logic [SEL_WIDTH-1:0]  fifo_d [DATA_FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [REQUESTERS-1:0] eligible_s;
    logic [SEL_WIDTH:0]    cand_s;
    logic                  found_s;
    logic [SEL_WIDTH-1:0]  pick_s;
    logic                  mcmd_valid_s;
    logic [SEL_WIDTH-1:0]  command_select_s;
    logic [REQUESTERS-1:0] scmd_accept_s;
    logic                  cmd_ack_s;
    logic                  push_s;
    logic [SEL_WIDTH-1:0]  head_s;
    logic                  empty_s;
    logic                  mdata_valid_s;
    logic                  mdata_last_s;
    logic [REQUESTERS-1:0] sdata_accept_s;
    logic                  pop_s;

    // Command arbitration, lock tracking and round-robin pointer update
    always_comb begin
        eligible_s       = '0;
        cand_s           = '0;
        found_s          = 1'b0;
        pick_s           = rr_ptr_q;
        mcmd_valid_s     = 1'b0;
        command_select_s = cmd_sel_q;
        scmd_accept_s    = '0;
        // Reset gates eligibility so the command side is quiet while i_rst_n is low
        for (int r = 0; r < REQUESTERS; r++) begin
            eligible_s[r] = i_rst_n && bus.i_mcmd_valid[r] &&
                            (!bus.i_mcmd_with_data[r] || (count_q < DEPTH_C));
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            cand_s = {1'b0, rr_ptr_q} + (SEL_WIDTH + 1)'(i);
            if (cand_s >= REQ_C) begin
                cand_s = cand_s - REQ_C;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && eligible_s[cand_s[SEL_WIDTH-1:0]]) begin
                found_s = 1'b1;
                pick_s  = cand_s[SEL_WIDTH-1:0];
            end else begin
                found_s = found_s;
            end
        end
        if (lock_q) begin
            mcmd_valid_s     = i_rst_n && bus.i_mcmd_valid[cmd_sel_q];
            command_select_s = cmd_sel_q;
        end else if (found_s) begin
            mcmd_valid_s     = 1'b1;
            command_select_s = pick_s;
        end else begin
            mcmd_valid_s     = 1'b0;
            command_select_s = cmd_sel_q;
        end
        cmd_ack_s = mcmd_valid_s && bus.i_scmd_accept;
        for (int r = 0; r < REQUESTERS; r++) begin
            scmd_accept_s[r] = cmd_ack_s && (command_select_s == SEL_WIDTH'(r));
        end
        push_s    = cmd_ack_s && bus.i_mcmd_with_data[command_select_s];
        lock_d    = (lock_q || mcmd_valid_s) && !cmd_ack_s;
        cmd_sel_d = command_select_s;
        if (cmd_ack_s) begin
            rr_ptr_d = (command_select_s == LAST_C) ? {SEL_WIDTH{1'b0}}
                                                    : command_select_s + SEL_WIDTH'(1);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Data channel steering from the FIFO head and FIFO bookkeeping
    always_comb begin
        head_s         = fifo_q[rd_ptr_q];
        empty_s        = (count_q == {CNT_W{1'b0}});
        mdata_valid_s  = !empty_s && bus.i_mdata_valid[head_s];
        mdata_last_s   = !empty_s && bus.i_mdata_last[head_s];
        sdata_accept_s = '0;
        for (int r = 0; r < REQUESTERS; r++) begin
            sdata_accept_s[r] = !empty_s && bus.i_sdata_accept && (head_s == SEL_WIDTH'(r));
        end
        pop_s  = mdata_valid_s && mdata_last_s && bus.i_sdata_accept;
        fifo_d = fifo_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = command_select_s;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d         = wr_ptr_q;
        end
        rd_ptr_d = pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            cmd_sel_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < DATA_FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            cmd_sel_q <= cmd_sel_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            fifo_q    <= fifo_d;
        end
    end

    assign bus.o_mcmd_valid     = mcmd_valid_s;
    assign bus.o_command_select = command_select_s;
    assign bus.o_scmd_accept    = scmd_accept_s;
    assign bus.o_mdata_valid    = mdata_valid_s;
    assign bus.o_mdata_last     = mdata_last_s;
    assign bus.o_sdata_accept   = sdata_accept_s;
    assign bus.o_data_select    = head_s;

    pzcorebus_request_scheduler_checker #(
        .REQUESTERS      (REQUESTERS),
        .DATA_FIFO_DEPTH (DATA_FIFO_DEPTH)
    ) u_checker (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_push           (push_s),
        .i_pop            (pop_s),
        .i_count          (count_q),
        .i_lock           (lock_q),
        .i_command_select (command_select_s),
        .i_scmd_accept    (scmd_accept_s),
        .i_sdata_accept   (sdata_accept_s)
    );
endmodule

// Protocol properties of the scheduler: FIFO overflow/underflow, grant stability, onehot accepts.
module pzcorebus_request_scheduler_checker #(
    parameter int  REQUESTERS      = 2,
    parameter int  DATA_FIFO_DEPTH = 4,
    localparam int SEL_WIDTH       = $clog2(REQUESTERS),
    localparam int CNT_W           = $clog2(DATA_FIFO_DEPTH) + 1
) (
    input logic                  i_clk,
    input logic                  i_rst_n,
    input logic                  i_push,
    input logic                  i_pop,
    input logic [CNT_W-1:0]      i_count,
    input logic                  i_lock,
    input logic [SEL_WIDTH-1:0]  i_command_select,
    input logic [REQUESTERS-1:0] i_scmd_accept,
    input logic [REQUESTERS-1:0] i_sdata_accept
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DATA_FIFO_DEPTH);

    a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_push && (i_count == DEPTH_C)));
    a_no_pop_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(i_pop && (i_count == {CNT_W{1'b0}})));
    a_lock_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_lock |-> $stable(i_command_select));
    a_scmd_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(i_scmd_accept));
    a_sdata_onehot0: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(i_sdata_accept));
endmodule

// File: doc/pzcorebus_request_scheduler.md
Name: pzcorebus_request_scheduler

Overview:
Sequences a shared corebus request path, such as an upsizer request path, between REQUESTERS independent request sources.
- Command channel: round-robin arbitration.
- Write-data channel: replays the command grant order, so data bursts are never interleaved.
- Payloads are not carried; the block drives select indices to external command/data muxes in front of the shared path.

Parameters:
REQUESTERS, 2, number of request sources (>=2)
DATA_FIFO_DEPTH, 4, max write commands accepted whose data burst has not completed (>=2, power of 2)
SEL_WIDTH, $clog2(REQUESTERS), width of select indices (derived, not overridden)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_mcmd_valid  input  REQUESTERS  per-requester command valid
i_mcmd_with_data  input  REQUESTERS  command carries write data (write/atomic types), qualified by i_mcmd_valid
o_scmd_accept  output  REQUESTERS  per-requester command accept
i_mdata_valid  input  REQUESTERS  per-requester write-data valid
i_mdata_last  input  REQUESTERS  per-requester last beat of burst
o_sdata_accept  output  REQUESTERS  per-requester data accept
o_mcmd_valid  output  1  command valid to shared path
i_scmd_accept  input  1  command accept from shared path
o_command_select  output  SEL_WIDTH  requester index driving command mux
o_mdata_valid  output  1  data valid to shared path
o_mdata_last  output  1  last flag to shared path
i_sdata_accept  input  1  data accept from shared path
o_data_select  output  SEL_WIDTH  requester index driving data mux

Behaviour:
- Clock and reset: single clock i_clk; reset is asynchronous, active-low, on i_rst_n.
- Reset values:
  - all outputs 0; selects 0.
  - round-robin pointer 0; lock clear; data FIFO empty.
- Eligibility: requester r is eligible when i_mcmd_valid[r] && (!i_mcmd_with_data[r] || fifo_count < DATA_FIFO_DEPTH).
  - Full check uses the registered count only; a same-cycle pop does not free a slot for a push.
- Command arbitration (combinational, zero latency):
  - When unlocked, pick the first eligible index starting at the pointer and wrapping modulo REQUESTERS.
  - o_mcmd_valid = any eligible; o_command_select = pick.
  - With no eligible requester, o_command_select holds its previous value.
- Lock:
  - Set when o_mcmd_valid && !i_scmd_accept.
  - While set, the grant is frozen to the locked index and o_mcmd_valid = i_mcmd_valid[locked]; requesters must hold valid until accepted.
  - Cleared on command ack.
- Command accept: o_scmd_accept[r] = i_scmd_accept && o_mcmd_valid && (o_command_select == r); all other bits 0.
- On command ack:
  - pointer <= (select + 1) mod REQUESTERS.
  - If with_data, push select into the data FIFO.
- Data channel:
  - o_data_select = FIFO head.
  - FIFO empty: o_mdata_valid = 0, o_mdata_last = 0, all o_sdata_accept = 0.
  - FIFO non-empty: o_mdata_valid = i_mdata_valid[head]; o_mdata_last = i_mdata_last[head]; o_sdata_accept[head] = i_sdata_accept; other bits 0.
  - Pop on o_mdata_valid && o_mdata_last && i_sdata_accept.
- Push-to-data latency: 1 cycle. Data presented by a requester in the same cycle as its command ack is not forwarded until the next cycle.
- Data valid from a non-head requester is ignored (held off, not dropped).
- Simultaneous push and pop: count unchanged, head advances.
- Pointer arithmetic:
  - FIFO pointers wrap modulo DATA_FIFO_DEPTH.
  - Count width is $clog2(DATA_FIFO_DEPTH)+1.
- Reset mid-burst: lock, pointer and FIFO are discarded immediately; the next command after reset re-arbitrates from index 0.
- Assertions:
  - no push when full; no pop when empty.
  - o_command_select stable while locked.
  - o_scmd_accept and o_sdata_accept each onehot0.

Test Plan:
- REQUESTERS=2, both issue non-data reads continuously, i_scmd_accept=1 -> grants alternate 0,1,0,1, one accept per cycle.
- Req0 write with 4-beat burst, then req1 write with 2-beat burst; req1 data valid first -> data forwarded in order 0,0,0,0(last),1,1(last); req1 data held until req0 last accepted.
- i_scmd_accept=0 for 3 cycles while req1 is granted and req0 raises valid -> o_command_select stays 1; req0 granted only after req1 ack.
- DATA_FIFO_DEPTH=2, 2 write commands accepted with no data -> third write blocked (o_mcmd_valid=0); a concurrent read from the other requester is still granted; first burst last ack -> write accepted the following cycle.
- Pop and push in the same cycle with count=1 -> count stays 1, o_data_select moves to the new head.
- Assert i_rst_n=0 mid-burst with FIFO count 2 -> all outputs 0 asynchronously; after release, FIFO is empty and arbitration starts at requester 0.
